// File: rtl/bpc_frame_sched.sv
// BPC time-signal frame scheduler: turns a loaded time word into a 20-second
// frame of base-4 symbols, each sent as a carrier-reduced pulse of (sym+1)/10 s.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | carrier on, waiting for en and a received time word
// ST_WAIT_TICK | armed; next tick latches the time word and starts second 0
// ST_RUN     | sending the frame, tick_cnt/sec_idx advancing on ticks
module bpc_frame_sched #(
  parameter int TICKS_PER_SEC = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_10ms,
  input  logic       en,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [4:0] t_hour,
  input  logic [5:0] t_min,
  input  logic [2:0] t_wday,
  input  logic [4:0] t_day,
  input  logic [3:0] t_mon,
  input  logic [5:0] t_year,
  output logic       bpc,
  output logic       bpc_n,
  output logic       frame_start,
  output logic [4:0] sec_idx
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_TICK, ST_RUN} state_t;

  localparam logic [7:0] TC_LAST  = 8'(TICKS_PER_SEC - 1);
  localparam logic [7:0] LEN_SYM0 = 8'(1 * (TICKS_PER_SEC / 10));
  localparam logic [7:0] LEN_SYM1 = 8'(2 * (TICKS_PER_SEC / 10));
  localparam logic [7:0] LEN_SYM2 = 8'(3 * (TICKS_PER_SEC / 10));
  localparam logic [7:0] LEN_SYM3 = 8'(4 * (TICKS_PER_SEC / 10));
  localparam logic [4:0] SEC_LAST = 5'd19;

  state_t      state, state_next;
  logic [7:0]  tick_cnt;
  logic [1:0]  seg;
  logic        have_time;
  logic [28:0] pending, shadow;

  logic        start_frame, wrap_sec, wrap_frame;
  logic [4:0]  sh_hour, sh_day;
  logic [5:0]  sh_min, sh_year;
  logic [2:0]  sh_wday;
  logic [3:0]  sh_mon, hour12;
  logic        pm, p3_par, p4;
  logic [1:0]  sym;
  logic [7:0]  low_len;

  assign load_ready = 1'b1;

  assign {sh_hour, sh_min, sh_wday, sh_day, sh_mon, sh_year} = shadow;

  assign start_frame = (state == ST_WAIT_TICK) && tick_10ms && en;
  assign wrap_sec    = (state == ST_RUN) && tick_10ms && en && (tick_cnt == TC_LAST);
  assign wrap_frame  = wrap_sec && (sec_idx == SEC_LAST);
  assign frame_start = start_frame || wrap_frame;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (have_time) state_next = ST_WAIT_TICK;
      ST_WAIT_TICK: if (tick_10ms) state_next = ST_RUN;
      ST_RUN:       state_next = ST_RUN;
      default:      state_next = ST_IDLE;
    endcase
    if (!en) state_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      shadow    <= '0;
      have_time <= 1'b0;
      tick_cnt  <= '0;
      sec_idx   <= '0;
      seg       <= '0;
    end else begin
      if (load_valid) begin
        pending   <= {t_hour, t_min, t_wday, t_day, t_mon, t_year};
        have_time <= 1'b1;
      end
      if (!en) begin
        tick_cnt <= '0;
        sec_idx  <= '0;
      end else if (start_frame) begin
        shadow   <= pending;
        tick_cnt <= '0;
        sec_idx  <= '0;
      end else if (state == ST_RUN && tick_10ms) begin
        if (wrap_sec) begin
          tick_cnt <= '0;
          if (wrap_frame) begin
            // pending is read before any same-cycle load lands in it
            sec_idx <= '0;
            shadow  <= pending;
          end else begin
            sec_idx <= sec_idx + 5'd1;
          end
        end else begin
          tick_cnt <= tick_cnt + 8'd1;
        end
      end
      if (state != ST_RUN)  seg <= 2'd0;
      else if (wrap_frame)  seg <= (seg == 2'd2) ? 2'd0 : seg + 2'd1;
    end
  end

  always_comb begin
    if (sh_hour >= 5'd24)      hour12 = 4'(sh_hour - 5'd24);
    else if (sh_hour >= 5'd12) hour12 = 4'(sh_hour - 5'd12);
    else                       hour12 = sh_hour[3:0];
  end

  assign pm     = (sh_hour >= 5'd12);
  assign p3_par = ^{seg, hour12, sh_min, sh_wday};
  assign p4     = ^{sh_day, sh_mon, sh_year};

  always_comb begin
    sym = 2'd0;
    case (sec_idx)
      5'd1:  sym = seg;
      5'd3:  sym = hour12[3:2];
      5'd4:  sym = hour12[1:0];
      5'd5:  sym = sh_min[5:4];
      5'd6:  sym = sh_min[3:2];
      5'd7:  sym = sh_min[1:0];
      5'd8:  sym = {1'b0, sh_wday[2]};
      5'd9:  sym = sh_wday[1:0];
      5'd10: sym = {pm, p3_par};
      5'd11: sym = {1'b0, sh_day[4]};
      5'd12: sym = sh_day[3:2];
      5'd13: sym = sh_day[1:0];
      5'd14: sym = sh_mon[3:2];
      5'd15: sym = sh_mon[1:0];
      5'd16: sym = sh_year[5:4];
      5'd17: sym = sh_year[3:2];
      5'd18: sym = sh_year[1:0];
      5'd19: sym = {1'b0, p4};
      default: sym = 2'd0;
    endcase
  end

  always_comb begin
    case (sym)
      2'd0:    low_len = LEN_SYM0;
      2'd1:    low_len = LEN_SYM1;
      2'd2:    low_len = LEN_SYM2;
      default: low_len = LEN_SYM3;
    endcase
  end

  // second 0 is the sync mark: carrier stays on for the whole second
  assign bpc   = !((state == ST_RUN) && (sec_idx != 5'd0) && (tick_cnt < low_len));
  assign bpc_n = !bpc;

endmodule
